sm_be_event_arbiter: RTL and testbench

Shares one surveillance-module event/report channel among NUM_PORTS BE destination extractors. Each extractor emits single-cycle, non-stallable (valid, dest) pulses when a BE packet's destination flit passes its monitored link. This block buffers each port's events in a small per-port FIFO and arbitrates round-robin onto one valid/ready output. It also flags overflow and out-of-range destinations per port and keeps a saturating drop counter.

---
 rtl/sm_be_pkg.sv | 23 ++
 rtl/sm_be_evt_fifo.sv | 51 +++++
 rtl/sm_be_event_arbiter.sv | 136 +++++++++++++
 tb/tb_sm_be_event_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_be_pkg.sv
// Shared types and width helpers for the surveillance-module BE event path.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sm_be_pkg;

    // Bit width needed to index n items; never less than one bit.
    function automatic int sm_be_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Default system geometry used by the BE extractors.
    localparam int SM_BE_NUM_PORTS = 4;
    localparam int SM_BE_NUM_TILES = 9;
    localparam int SM_BE_PORT_W    = sm_be_width(SM_BE_NUM_PORTS);
    localparam int SM_BE_TILE_W    = sm_be_width(SM_BE_NUM_TILES);

    // One destination event as reported on the surveillance channel.
    typedef struct packed {
        logic [SM_BE_PORT_W-1:0] port;
        logic [SM_BE_TILE_W-1:0] dest;
    } sm_be_evt_t;

endpackage

// File: rtl/sm_be_evt_fifo.sv
// Single-clock FIFO of destination entries, one per monitored port.
// Latency: a pushed entry is visible at dout the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module sm_be_evt_fifo
    import sm_be_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB separates full (MSBs differ) from empty (equal).
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; pointers wrap naturally at 2*DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/sm_be_event_arbiter.sv
// Buffers per-port BE destination events and round-robins them onto one channel.
// Latency: 2 cycles from in_valid pulse to earliest out_valid; registered output.
// Backpressure: inputs cannot stall; full FIFOs drop (overflow + drop_count), output holds until ready.
module sm_be_event_arbiter
    import sm_be_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int NUM_TILES  = 9,
    parameter  int FIFO_DEPTH = 4,
    parameter  int CNT_WIDTH  = 16,
    localparam int TILE_WIDTH = sm_be_width(NUM_TILES),
    localparam int PORT_WIDTH = sm_be_width(NUM_PORTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_PORTS-1:0]             in_valid,
    input  logic [NUM_PORTS*TILE_WIDTH-1:0]  in_dest,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [PORT_WIDTH-1:0]            out_port,
    output logic [TILE_WIDTH-1:0]            out_dest,
    output logic [NUM_PORTS-1:0]             overflow,
    output logic [NUM_PORTS-1:0]             dest_err,
    input  logic                             err_clr,
    output logic [CNT_WIDTH-1:0]             drop_count
);

    localparam logic [TILE_WIDTH:0] TILE_LIMIT = (TILE_WIDTH+1)'(NUM_TILES);
    localparam int                  SUM_W      = CNT_WIDTH + PORT_WIDTH + 1;

    logic [NUM_PORTS-1:0]  fifo_empty;
    logic [NUM_PORTS-1:0]  fifo_full;
    logic [TILE_WIDTH-1:0] fifo_head [NUM_PORTS];
    logic [NUM_PORTS-1:0]  push;
    logic [NUM_PORTS-1:0]  pop;
    logic [NUM_PORTS-1:0]  drop;
    logic [NUM_PORTS-1:0]  bad_dest;

    logic [PORT_WIDTH-1:0] rr_ptr;
    logic                  gnt_found;
    logic [PORT_WIDTH-1:0] gnt_port;
    logic [TILE_WIDTH-1:0] gnt_dest;
    logic                  load;

    logic [PORT_WIDTH:0]   n_drops;
    logic [SUM_W-1:0]      cnt_sum;
    logic [CNT_WIDTH-1:0]  cnt_next;

    // Per-port capture: range check, push, and drop detection.
    // A full FIFO that is popped this cycle still accepts the push.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [TILE_WIDTH-1:0] dest_p;

        assign dest_p      = in_dest[p*TILE_WIDTH +: TILE_WIDTH];
        assign bad_dest[p] = in_valid[p] && ({1'b0, dest_p} >= TILE_LIMIT);
        assign push[p]     = in_valid[p] && !bad_dest[p];
        assign pop[p]      = load && (gnt_port == PORT_WIDTH'(p));
        assign drop[p]     = push[p] && fifo_full[p] && !pop[p];

        sm_be_evt_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (TILE_WIDTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[p]),
            .din   (dest_p),
            .pop   (pop[p]),
            .dout  (fifo_head[p]),
            .full  (fifo_full[p]),
            .empty (fifo_empty[p])
        );
    end

    // Round-robin grant: nearest non-empty port after rr_ptr wins.
    // Scanning from farthest to nearest lets the last hit be the winner.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_found = 1'b0;
        gnt_port  = '0;
        gnt_dest  = '0;
        for (int off = NUM_PORTS; off >= 1; off--) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!fifo_empty[idx]) begin
                gnt_found = 1'b1;
                gnt_port  = PORT_WIDTH'(idx);
                gnt_dest  = fifo_head[idx];
            end
        end
    end

    assign load = gnt_found && (!out_valid || out_ready);

    // Saturating drop total; several ports may drop in one cycle.
    always_comb begin
        n_drops = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            n_drops = n_drops + (PORT_WIDTH+1)'(drop[p]);
        end
        cnt_sum  = SUM_W'(drop_count) + SUM_W'(n_drops);
        cnt_next = (cnt_sum > SUM_W'({CNT_WIDTH{1'b1}})) ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end

    // Output slot and round-robin pointer; slot holds steady while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_port  <= '0;
            out_dest  <= '0;
            rr_ptr    <= PORT_WIDTH'(NUM_PORTS - 1);
        end else if (load) begin
            out_valid <= 1'b1;
            out_port  <= gnt_port;
            out_dest  <= gnt_dest;
            rr_ptr    <= gnt_port;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags (a new error beats err_clr) and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= '0;
            dest_err   <= '0;
            drop_count <= '0;
        end else begin
            overflow   <= (overflow & ~{NUM_PORTS{err_clr}}) | drop;
            dest_err   <= (dest_err & ~{NUM_PORTS{err_clr}}) | bad_dest;
            drop_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_sm_be_event_arbiter.sv
module tb_sm_be_event_arbiter;

    localparam int NP = 4;
    localparam int NT = 9;
    localparam int FD = 4;
    localparam int CW = 4;
    localparam int TW = 4;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     in_valid = '0;
    logic [NP*TW-1:0]  in_dest = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [PW-1:0]     out_port;
    logic [TW-1:0]     out_dest;
    logic [NP-1:0]     overflow;
    logic [NP-1:0]     dest_err;
    logic              err_clr = 1'b0;
    logic [CW-1:0]     drop_count;

    always #5 clk = ~clk;

    sm_be_event_arbiter #(
        .NUM_PORTS  (NP),
        .NUM_TILES  (NT),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_dest    (in_dest),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_port   (out_port),
        .out_dest   (out_dest),
        .overflow   (overflow),
        .dest_err   (dest_err),
        .err_clr    (err_clr),
        .drop_count (drop_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-port queues, a one-entry output slot, RR pointer.
    int        mq [NP][$];
    int        m_sv, m_sp, m_sd, m_rr, m_cnt;
    bit [NP-1:0] m_ovf, m_derr;
    int        exp_port_q [$];
    int        exp_dest_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit [NP*TW-1:0] dv(input int d0, input int d1, input int d2, input int d3);
        bit [3:0] a, b, c, e;
        a = d0[3:0]; b = d1[3:0]; c = d2[3:0]; e = d3[3:0];
        return {e, c, b, a};
    endfunction

    // Advance the model across one clock edge given that cycle's inputs.
    task automatic model_step(input bit [NP-1:0] v, input bit [NP*TW-1:0] d,
                              input bit rdy, input bit clr, input bit r);
        int  g, pd, dst, idx;
        int  pre [NP];
        bit  found, ld;
        if (r) begin
            for (int p = 0; p < NP; p++) mq[p].delete();
            m_sv = 0; m_sp = 0; m_sd = 0; m_rr = NP - 1; m_cnt = 0;
            m_ovf = '0; m_derr = '0;
            exp_port_q.delete();
            exp_dest_q.delete();
            return;
        end
        found = 0; g = 0; pd = 0;
        for (int off = 1; off <= NP; off++) begin
            idx = (m_rr + off) % NP;
            if (!found && mq[idx].size() > 0) begin
                found = 1;
                g = idx;
            end
        end
        ld = found && (m_sv == 0 || rdy);
        for (int p = 0; p < NP; p++) pre[p] = mq[p].size();
        if (ld) pd = mq[g].pop_front();
        if (clr) begin
            m_ovf = '0;
            m_derr = '0;
        end
        for (int p = 0; p < NP; p++) begin
            if (v[p]) begin
                dst = int'(d[p*TW +: TW]);
                if (dst >= NT) m_derr[p] = 1'b1;
                else if (pre[p] < FD || (ld && g == p)) mq[p].push_back(dst);
                else begin
                    m_ovf[p] = 1'b1;
                    if (m_cnt < (1 << CW) - 1) m_cnt++;
                end
            end
        end
        if (ld) begin
            m_sv = 1; m_sp = g; m_sd = pd; m_rr = g;
            exp_port_q.push_back(g);
            exp_dest_q.push_back(pd);
        end else if (rdy) begin
            m_sv = 0;
        end
    endtask

    // Drive one cycle of inputs, step the model, then compare after the edge.
    task automatic tick(input bit [NP-1:0] v, input bit [NP*TW-1:0] d,
                        input bit rdy, input bit clr, input bit r);
        in_valid = v; in_dest = d; out_ready = rdy; err_clr = clr; rst = r;
        model_step(v, d, rdy, clr, r);
        @(posedge clk);
        #1;
        check("out_valid", int'(out_valid), m_sv);
        if (m_sv != 0) begin
            check("out_port", int'(out_port), m_sp);
            check("out_dest", int'(out_dest), m_sd);
        end
        check("overflow", int'(overflow), int'(m_ovf));
        check("dest_err", int'(dest_err), int'(m_derr));
        check("drop_count", int'(drop_count), m_cnt);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) tick('0, '0, rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        tick('0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: every accepted event must match the next expected one.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_port_q.size() == 0) begin
                check("unexpected_delivery", int'(out_port), -1);
            end else begin
                check("sb_port", int'(out_port), exp_port_q.pop_front());
                check("sb_dest", int'(out_dest), exp_dest_q.pop_front());
            end
        end
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_port", int'(out_port), 0);
        check("rst_out_dest", int'(out_dest), 0);
        check("rst_drop_count", int'(drop_count), 0);

        // Single event latency: pulse in cycle 0, visible in cycle 2, gone in 3
        tick(4'b0100, dv(0, 0, 5, 0), 1'b1, 1'b0, 1'b0);
        check("lat_c1_valid", int'(out_valid), 0);
        tick('0, '0, 1'b1, 1'b0, 1'b0);
        check("lat_c2_valid", int'(out_valid), 1);
        check("lat_c2_port", int'(out_port), 2);
        check("lat_c2_dest", int'(out_dest), 5);
        tick('0, '0, 1'b1, 1'b0, 1'b0);
        check("lat_c3_valid", int'(out_valid), 0);

        // All-port burst twice: port order 0..3 each time, back to back
        do_reset();
        for (int b = 0; b < 2; b++) begin
            tick(4'b1111, dv(1, 2, 3, 4), 1'b1, 1'b0, 1'b0);
            for (int i = 0; i < NP; i++) begin
                tick('0, '0, 1'b1, 1'b0, 1'b0);
                check("rr_port", int'(out_port), i);
                check("rr_dest", int'(out_dest), i + 1);
                check("rr_valid", int'(out_valid), 1);
            end
            tick('0, '0, 1'b1, 1'b0, 1'b0);
        end

        // Stall: 5 events fit (slot + 4), the 6th drops
        do_reset();
        for (int i = 0; i < 5; i++) tick(4'b0010, dv(0, i, 0, 0), 1'b0, 1'b0, 1'b0);
        check("stall5_drops", int'(drop_count), 0);
        check("stall5_ovf", int'(overflow), 0);
        tick(4'b0010, dv(0, 5, 0, 0), 1'b0, 1'b0, 1'b0);
        check("stall6_ovf", int'(overflow), 2);
        check("stall6_drops", int'(drop_count), 1);
        check("stall_dest_stable", int'(out_dest), 0);
        idle(8, 1'b1);

        // Full FIFO pushed while popped: no loss
        do_reset();
        for (int i = 0; i < 5; i++) tick(4'b0001, dv(i + 1, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        tick(4'b0001, dv(7, 0, 0, 0), 1'b1, 1'b0, 1'b0);
        check("fullpop_ovf", int'(overflow), 0);
        check("fullpop_drops", int'(drop_count), 0);
        idle(8, 1'b1);

        // Out-of-range destinations
        do_reset();
        tick(4'b1000, dv(0, 0, 0, 9), 1'b1, 1'b0, 1'b0);
        check("derr_set", int'(dest_err), 8);
        idle(3, 1'b1);
        check("derr_no_out", int'(out_valid), 0);
        tick(4'b1000, dv(0, 0, 0, 12), 1'b1, 1'b1, 1'b0);
        check("derr_set_wins", int'(dest_err[3]), 1);
        tick('0, '0, 1'b1, 1'b1, 1'b0);
        check("derr_cleared", int'(dest_err), 0);

        // Counter saturation at CNT_WIDTH=4
        do_reset();
        for (int i = 0; i < 5; i++) tick(4'b0001, dv(1, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick(4'b0001, dv(2, 0, 0, 0), 1'b0, 1'b0, 1'b0);
        check("sat_15", int'(drop_count), 15);
        tick(4'b0001, dv(2, 0, 0, 0), 1'b0, 1'b1, 1'b0);
        check("sat_hold", int'(drop_count), 15);
        check("sat_clr_keeps_cnt", int'(overflow), 1);

        // Reset mid-burst discards everything
        tick(4'b1111, dv(3, 3, 3, 3), 1'b1, 1'b0, 1'b0);
        tick(4'b1111, dv(4, 4, 4, 4), 1'b1, 1'b0, 1'b0);
        tick('0, '0, 1'b1, 1'b0, 1'b1);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_cnt", int'(drop_count), 0);
        idle(6, 1'b1);
        check("midrst_quiet", int'(out_valid), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            bit [NP-1:0] v;
            v = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            tick(v,
                 dv($urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 9)),
                 ($urandom_range(0, 3) != 0) || (c % 100 > 70),
                 $urandom_range(0, 31) == 0,
                 $urandom_range(0, 299) == 0);
        end

        // Drain and confirm every expected event was delivered
        idle(30, 1'b1);
        check("drained", exp_port_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
